// File: rtl/sha256_msg_sched.sv
// sha256_msg_sched: SHA-256 / SHA-512 message schedule expander over a 16-word sliding window.
// Latency: W[0] appears one cycle after block acceptance, then one word per accepted w_data.
// Backpressure: w_ready low freezes window, t and outputs; blk_ready is low during RUN, with one idle bubble between blocks.
// Option: define SHA256_MSG_SCHED_TIDX_EN to add output t_idx (current word index in RUN, 0 otherwise).
module sha256_msg_sched #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     blk_valid,
  output logic                     blk_ready,
  input  logic [16*WORD_W-1:0]     blk_data,
  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [WORD_W-1:0]        w_data,
  output logic                     w_last,
`ifdef SHA256_MSG_SCHED_TIDX_EN
  output logic                     busy,
  output logic [$clog2(ROUNDS)-1:0] t_idx
`else
  output logic                     busy
`endif
);

  localparam int TW = $clog2(ROUNDS);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  // Only the two standard word widths and a sane round count are meaningful.
  generate
    if (!(WORD_W == 32 || WORD_W == 64)) begin : g_bad_word_w
      $error("sha256_msg_sched: WORD_W must be 32 or 64");
    end
    if (ROUNDS < 16 || ROUNDS > 80) begin : g_bad_rounds
      $error("sha256_msg_sched: ROUNDS must be within 16..80");
    end
  endgenerate

  // Rotate right; the modulo keeps the unused width's constants well-formed.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int n);
    int s;
    s = n % WORD_W;
    return (x >> s) | (x << ((WORD_W - s) % WORD_W));
  endfunction

  // Small sigma 0 of the selected hash family.
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    else              return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  // Small sigma 1 of the selected hash family.
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    else              return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  logic              r_state;
  logic [TW-1:0]     r_t;
  logic [WORD_W-1:0] r_win [16];

  logic              w_run;
  logic              w_hs;
  logic              w_t_last;
  logic              w_accept;
  logic [WORD_W-1:0] w_next;

  assign w_run    = (r_state == ST_RUN);
  assign w_hs     = w_run && w_ready;
  assign w_t_last = (r_t == TW'(ROUNDS - 1));
  assign w_accept = (r_state == ST_IDLE) && blk_valid;
  assign w_next   = sig1(r_win[14]) + r_win[9] + sig0(r_win[1]) + r_win[0];

  // Control: IDLE accepts a block, RUN ends on the handshake of the last word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_t     <= '0;
    end else if (w_accept) begin
      r_state <= ST_RUN;
      r_t     <= '0;
    end else if (w_hs) begin
      if (w_t_last) begin
        r_state <= ST_IDLE;
        r_t     <= '0;
      end else begin
        r_t <= r_t + TW'(1);
      end
    end
  end

  // Window: load the block on acceptance, slide and append the next expanded word on each handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_win[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < 16; i++) r_win[i] <= blk_data[(15-i)*WORD_W +: WORD_W];
    end else if (w_hs) begin
      for (int i = 0; i < 15; i++) r_win[i] <= r_win[i+1];
      r_win[15] <= w_next;
    end
  end

  assign blk_ready = !w_run;
  assign w_valid   = w_run;
  assign busy      = w_run;
  assign w_data    = w_run ? r_win[0] : '0;
  assign w_last    = w_run && w_t_last;
`ifdef SHA256_MSG_SCHED_TIDX_EN
  assign t_idx     = w_run ? r_t : '0;
`endif

endmodule

// File: tb/tb_sha256_msg_sched.sv
// tb_sha256_msg_sched: checks a 32-bit/64-round and a 64-bit/80-round instance against a
// textbook W[t] recurrence computed over a flat array, with stalls, resets and stray blk_valid.
module tb_sha256_msg_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          w_ready;
  logic          blk_valid32, blk_ready32, w_valid32, w_last32, busy32;
  logic [511:0]  blk_data32;
  logic [31:0]   w_data32;
  logic          blk_valid64, blk_ready64, w_valid64, w_last64, busy64;
  logic [1023:0] blk_data64;
  logic [63:0]   w_data64;
`ifdef SHA256_MSG_SCHED_TIDX_EN
  logic [5:0]    t_idx32;
  logic [6:0]    t_idx64;
`endif

  sha256_msg_sched #(.WORD_W(32), .ROUNDS(64)) u_dut32 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid32), .blk_ready(blk_ready32),
    .blk_data(blk_data32), .w_valid(w_valid32), .w_ready(w_ready),
    .w_data(w_data32), .w_last(w_last32),
`ifdef SHA256_MSG_SCHED_TIDX_EN
    .t_idx(t_idx32),
`endif
    .busy(busy32)
  );

  sha256_msg_sched #(.WORD_W(64), .ROUNDS(80)) u_dut64 (
    .clk(clk), .rst(rst), .blk_valid(blk_valid64), .blk_ready(blk_ready64),
    .blk_data(blk_data64), .w_valid(w_valid64), .w_ready(w_ready),
    .w_data(w_data64), .w_last(w_last64),
`ifdef SHA256_MSG_SCHED_TIDX_EN
    .t_idx(t_idx64),
`endif
    .busy(busy64)
  );

  int          n_vec = 0;
  int          n_err = 0;
  bit          sel64 = 1'b0;
  int          word_w = 32;
  logic [63:0] msg   [16];
  logic [63:0] exp_w [80];
  logic [63:0] obs_w [80];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Views of whichever instance is under test.
  function automatic logic [63:0] o_dat();
    return sel64 ? w_data64 : {32'h0, w_data32};
  endfunction
  function automatic logic o_vld();
    return sel64 ? w_valid64 : w_valid32;
  endfunction
  function automatic logic o_last();
    return sel64 ? w_last64 : w_last32;
  endfunction
  function automatic logic o_brdy();
    return sel64 ? blk_ready64 : blk_ready32;
  endfunction
  function automatic logic o_busy();
    return sel64 ? busy64 : busy32;
  endfunction
`ifdef SHA256_MSG_SCHED_TIDX_EN
  function automatic logic [6:0] o_tidx();
    return sel64 ? t_idx64 : {1'b0, t_idx32};
  endfunction
`endif

  // Reference model: FIPS 180-4 schedule recurrence on a full W[] array.
  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
  endfunction
  function automatic logic [63:0] rotr(input logic [63:0] x, input int n, input int w);
    return ((x >> n) | (x << (w - n))) & wmask(w);
  endfunction
  function automatic logic [63:0] s0(input logic [63:0] x, input int w);
    if (w == 64) return rotr(x, 1, 64) ^ rotr(x, 8, 64) ^ (x >> 7);
    return rotr(x, 7, 32) ^ rotr(x, 18, 32) ^ (x >> 3);
  endfunction
  function automatic logic [63:0] s1(input logic [63:0] x, input int w);
    if (w == 64) return rotr(x, 19, 64) ^ rotr(x, 61, 64) ^ (x >> 6);
    return rotr(x, 17, 32) ^ rotr(x, 19, 32) ^ (x >> 10);
  endfunction

  task automatic build_exp(input int n);
    for (int t = 0; t < n; t++) begin
      if (t < 16) exp_w[t] = msg[t] & wmask(word_w);
      else exp_w[t] = (s1(exp_w[t-2], word_w) + exp_w[t-7] + s0(exp_w[t-15], word_w) + exp_w[t-16]) & wmask(word_w);
    end
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 16; i++) msg[i] = {$urandom(), $urandom()} & wmask(word_w);
  endtask

  task automatic offer_blk();
    for (int i = 0; i < 16; i++) begin
      blk_data32[(15-i)*32 +: 32] = msg[i][31:0];
      blk_data64[(15-i)*64 +: 64] = msg[i];
    end
    if (sel64) blk_valid64 = 1'b1;
    else       blk_valid32 = 1'b1;
  endtask

  task automatic drop_valid();
    blk_valid32 = 1'b0;
    blk_valid64 = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_vld"},  o_vld(),  1'b0);
    chk({tag, "_rdy"},  o_brdy(), 1'b1);
    chk({tag, "_busy"}, o_busy(), 1'b0);
    chk({tag, "_last"}, o_last(), 1'b0);
    chk({tag, "_dat"},  o_dat(),  64'h0);
`ifdef SHA256_MSG_SCHED_TIDX_EN
    chk({tag, "_tidx"}, o_tidx(), 64'h0);
`endif
  endtask

  // Called at a negedge while idle; returns at the negedge where W[0] should show.
  task automatic start_blk(input bit hold);
    chk("blk_rdy", o_brdy(), 1'b1);
    offer_blk();
    @(negedge clk);
    if (!hold) drop_valid();
  endtask

  // Consume n words; returns at the negedge after the last handshake (the idle bubble).
  task automatic recv(input int n, input int stall_at, input int stall_len,
                      input int abort_at, input bit pulse);
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) return;
      if (k == stall_at) begin
        w_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          chk("stall_vld", o_vld(), 1'b1);
          chk("stall_dat", o_dat(), exp_w[k]);
          chk("stall_last", o_last(), 1'(k == n - 1));
`ifdef SHA256_MSG_SCHED_TIDX_EN
          chk("stall_tidx", o_tidx(), 64'(k));
`endif
        end
        w_ready = 1'b1;
      end
      chk("w_vld", o_vld(), 1'b1);
      chk("w_busy", o_busy(), 1'b1);
      chk("w_brdy", o_brdy(), 1'b0);
      chk("w_dat", o_dat(), exp_w[k]);
      chk("w_last", o_last(), 1'(k == n - 1));
`ifdef SHA256_MSG_SCHED_TIDX_EN
      chk("w_tidx", o_tidx(), 64'(k));
`endif
      obs_w[k] = o_dat();
      if (pulse) begin
        if (sel64) begin
          blk_valid64 = 1'($urandom_range(0, 1));
          blk_data64  = {32{$urandom()}};
        end else begin
          blk_valid32 = 1'($urandom_range(0, 1));
          blk_data32  = {16{$urandom()}};
        end
      end
      @(negedge clk);
    end
    if (pulse) drop_valid();
  endtask

  initial begin
    rst = 1'b1; w_ready = 1'b1;
    blk_valid32 = 1'b0; blk_valid64 = 1'b0;
    blk_data32 = '0; blk_data64 = '0;
    repeat (2) @(negedge clk);
    sel64 = 1'b0; check_idle("rst32");
    sel64 = 1'b1; check_idle("rst64");
    rst = 1'b0;
    @(negedge clk);

    // "abc" padded block, SHA-256, no stalls.
    sel64 = 1'b0; word_w = 32;
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    msg[0] = 64'h6162_6380; msg[15] = 64'h18;
    build_exp(64);
    start_blk(1'b0);
    recv(64, -1, 0, -1, 1'b0);
    chk("abc_w16", obs_w[16], 64'h6162_6380);
    chk("abc_w17", obs_w[17], 64'h000F_0000);
    check_idle("abc_end");

    // Backpressure: 5 stalled cycles while W[3] is presented.
    rand_msg(); build_exp(64);
    start_blk(1'b0);
    recv(64, 3, 5, -1, 1'b0);
    check_idle("bp_end");

    // Reset while W[20] is presented, then a fresh block starts at W[0].
    rand_msg(); build_exp(64);
    start_blk(1'b0);
    recv(64, -1, 0, 20, 1'b0);
    rst = 1'b1;
    #1 check_idle("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    check_idle("post_rst");
    rand_msg(); build_exp(64);
    start_blk(1'b0);
    recv(64, -1, 0, -1, 1'b0);
    check_idle("rst_blk_end");

    // Stray blk_valid/blk_data during RUN must not disturb the stream.
    rand_msg(); build_exp(64);
    start_blk(1'b0);
    recv(64, 10, 2, -1, 1'b1);
    check_idle("pulse_end");

    // Back-to-back blocks with blk_valid held high: exactly one bubble.
    rand_msg(); build_exp(64);
    start_blk(1'b1);
    rand_msg(); offer_blk();
    recv(64, -1, 0, -1, 1'b0);
    chk("b2b_bubble_vld", o_vld(), 1'b0);
    chk("b2b_bubble_rdy", o_brdy(), 1'b1);
    build_exp(64);
    @(negedge clk);
    drop_valid();
    recv(64, -1, 0, -1, 1'b0);
    check_idle("b2b_end");

    // Random blocks with random stall placement.
    for (int b = 0; b < 3; b++) begin
      rand_msg(); build_exp(64);
      start_blk(1'b0);
      recv(64, $urandom_range(0, 63), $urandom_range(1, 4), -1, 1'b0);
      check_idle("rand32_end");
    end

    // SHA-512 instance: all-zero block, then random blocks.
    sel64 = 1'b1; word_w = 64;
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    build_exp(80);
    start_blk(1'b0);
    recv(80, -1, 0, -1, 1'b0);
    chk("zero_w79", obs_w[79], 64'h0);
    check_idle("zero_end");
    for (int b = 0; b < 2; b++) begin
      rand_msg(); build_exp(80);
      start_blk(1'b0);
      recv(80, $urandom_range(0, 79), $urandom_range(1, 4), -1, b == 1);
      check_idle("rand64_end");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
